// File: rtl/adc128s022_emulator_if.sv
// ----------------------------------------------------------------------------
// adc128s022_emulator_if
// SPI pin bundle shared by an ADC128S022 master and the emulator.
//   ADC_SCLK  : serial clock, master -> emulator (idles high)
//   ADC_CS_N  : chip select, master -> emulator (active low)
//   ADC_SADDR : address/data, master -> emulator (ADC DIN)
//   ADC_SDAT  : conversion data, emulator -> master (ADC DOUT)
// ----------------------------------------------------------------------------
interface adc128s022_emulator_if;
  logic ADC_SCLK;
  logic ADC_CS_N;
  logic ADC_SADDR;
  logic ADC_SDAT;

  modport master (
    output ADC_SCLK,
    output ADC_CS_N,
    output ADC_SADDR,
    input  ADC_SDAT
  );

  modport slave (
    input  ADC_SCLK,
    input  ADC_CS_N,
    input  ADC_SADDR,
    output ADC_SDAT
  );
endinterface

// File: rtl/adc128s022_emulator.sv
// ----------------------------------------------------------------------------
// adc128s022_emulator
// Pin-level SPI responder standing in for an ADC128S022. Channel values come
// from a parallel bus and are returned with the chip's 16-bit framing (four
// leading zeros + 12 data bits). The channel for the next frame is taken from
// the address bits the master shifts in on rising SCLK edges 3..5.
//
// Ports:
//   clk_in        : system clock, the only clock of the block
//   reset         : synchronous active-low reset
//   spi (slave)   : ADC_SCLK / ADC_CS_N / ADC_SADDR in, ADC_SDAT out (registered)
//   ch_data       : 8 x 12-bit channel values, channel k at [12k+11:12k]
//   frame_done    : one-cycle pulse on the 16th SCLK rise of a frame
//   frame_channel : channel of the word most recently loaded for output
//   busy          : high while a frame is in progress (CS low)
// ----------------------------------------------------------------------------
module adc128s022_emulator #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk_in,
  input  logic                  reset,
  adc128s022_emulator_if.slave  spi,
  input  logic [95:0]           ch_data,
  output logic                  frame_done,
  output logic [2:0]            frame_channel,
  output logic                  busy
);

  localparam int unsigned NUM_CH      = 8;
  localparam int unsigned CH_W        = 12;
  localparam int unsigned CH_SEL_W    = 3;
  localparam int unsigned WORD_W      = 16;
  localparam int unsigned CNT_W       = 5;
  localparam int unsigned FRAME_EDGES = 16;
  localparam int unsigned ADD2_RISE   = 3;
  localparam int unsigned ADD1_RISE   = 4;
  localparam int unsigned ADD0_RISE   = 5;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  // --------------------------------------------------------------------------
  // Input synchronizers and edge detection
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] saddr_sync;
  logic                   sclk_dly;
  logic                   cs_dly;
  logic                   sync_primed;
  logic                   cs_seen_high;

  // The CS chain resets to 1, so a CS pin held low through reset would look
  // like a fall once the chain flushes. cs_seen_high only arms after a real
  // high level has been sampled from the pin.
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      sclk_sync    <= '1;
      cs_sync      <= '1;
      saddr_sync   <= '0;
      sclk_dly     <= 1'b1;
      cs_dly       <= 1'b1;
      sync_primed  <= 1'b0;
      cs_seen_high <= 1'b0;
    end else begin
      sclk_sync   <= {sclk_sync[SYNC_STAGES-2:0], spi.ADC_SCLK};
      cs_sync     <= {cs_sync[SYNC_STAGES-2:0], spi.ADC_CS_N};
      saddr_sync  <= {saddr_sync[SYNC_STAGES-2:0], spi.ADC_SADDR};
      sclk_dly    <= sclk_sync[SYNC_STAGES-1];
      cs_dly      <= cs_sync[SYNC_STAGES-1];
      sync_primed <= 1'b1;
      if (sync_primed && cs_sync[0]) begin
        cs_seen_high <= 1'b1;
      end
    end
  end

  logic sclk_s;
  logic cs_n_s;
  logic saddr_s;
  logic sclk_rise_c;
  logic sclk_fall_c;
  logic cs_rise_c;
  logic cs_fall_c;

  assign sclk_s      = sclk_sync[SYNC_STAGES-1];
  assign cs_n_s      = cs_sync[SYNC_STAGES-1];
  assign saddr_s     = saddr_sync[SYNC_STAGES-1];
  assign sclk_rise_c = sclk_s & ~sclk_dly;
  assign sclk_fall_c = ~sclk_s & sclk_dly;
  assign cs_rise_c   = cs_n_s & ~cs_dly;
  assign cs_fall_c   = ~cs_n_s & cs_dly & cs_seen_high;

  // --------------------------------------------------------------------------
  // Channel word mux for the next frame
  // --------------------------------------------------------------------------
  logic [CH_SEL_W-1:0] next_ch_q;
  logic [CH_W-1:0]     ch_word_c;

  always_comb begin
    ch_word_c = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (next_ch_q == CH_SEL_W'(k)) begin
        ch_word_c = ch_data[k*CH_W +: CH_W];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Frame state machine
  // --------------------------------------------------------------------------
  logic [0:0]          state_q;
  logic [0:0]          state_d;
  logic [WORD_W-1:0]   shift_q;
  logic [WORD_W-1:0]   shift_d;
  logic [CNT_W-1:0]    rise_cnt_q;
  logic [CNT_W-1:0]    rise_cnt_d;
  logic [CH_SEL_W-1:0] next_ch_d;
  logic [1:0]          add_hi_q;
  logic [1:0]          add_hi_d;
  logic                frame_done_q;
  logic                frame_done_d;
  logic [CH_SEL_W-1:0] frame_channel_q;
  logic [CH_SEL_W-1:0] frame_channel_d;
  logic                busy_q;
  logic                busy_d;
  logic                load_c;

  // ADC_SDAT is the MSB of shift_q, so clearing shift_q also drives SDAT low.
  // A fall is numbered by the rises already seen in the frame: the fall that
  // precedes rise 1 is ignored, falls 1..15 shift, and fall 16 reloads.
  always_comb begin
    state_d         = state_q;
    shift_d         = shift_q;
    rise_cnt_d      = rise_cnt_q;
    next_ch_d       = next_ch_q;
    add_hi_d        = add_hi_q;
    frame_done_d    = 1'b0;
    frame_channel_d = frame_channel_q;
    load_c          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        shift_d = '0;
        if (cs_fall_c) begin
          state_d = ST_ACTIVE;
          load_c  = 1'b1;
        end
      end

      ST_ACTIVE: begin
        if (cs_rise_c) begin
          // Abort or normal end: CS rise wins over any SCLK edge this cycle.
          state_d = ST_IDLE;
          shift_d = '0;
        end else if (sclk_fall_c) begin
          if (rise_cnt_q == CNT_W'(FRAME_EDGES)) begin
            load_c = 1'b1;
          end else if (rise_cnt_q != '0) begin
            shift_d = {shift_q[WORD_W-2:0], 1'b0};
          end
        end else if (sclk_rise_c) begin
          rise_cnt_d = rise_cnt_q + CNT_W'(1);
          if (rise_cnt_d == CNT_W'(ADD2_RISE)) begin
            add_hi_d[1] = saddr_s;
          end else if (rise_cnt_d == CNT_W'(ADD1_RISE)) begin
            add_hi_d[0] = saddr_s;
          end else if (rise_cnt_d == CNT_W'(ADD0_RISE)) begin
            next_ch_d = {add_hi_q, saddr_s};
          end else if (rise_cnt_d == CNT_W'(FRAME_EDGES)) begin
            frame_done_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        shift_d = '0;
      end
    endcase

    // Frame load: four leading zeros, then the selected 12-bit sample.
    if (load_c) begin
      shift_d         = {4'b0000, ch_word_c};
      frame_channel_d = next_ch_q;
      rise_cnt_d      = '0;
    end

    busy_d = (state_d == ST_ACTIVE);
  end

  // State and registered outputs
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      state_q         <= ST_IDLE;
      shift_q         <= '0;
      rise_cnt_q      <= '0;
      next_ch_q       <= '0;
      add_hi_q        <= '0;
      frame_done_q    <= 1'b0;
      frame_channel_q <= '0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      shift_q         <= shift_d;
      rise_cnt_q      <= rise_cnt_d;
      next_ch_q       <= next_ch_d;
      add_hi_q        <= add_hi_d;
      frame_done_q    <= frame_done_d;
      frame_channel_q <= frame_channel_d;
      busy_q          <= busy_d;
    end
  end

  assign spi.ADC_SDAT  = shift_q[WORD_W-1];
  assign frame_done    = frame_done_q;
  assign frame_channel = frame_channel_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_adc128s022_emulator.sv
// ----------------------------------------------------------------------------
// tb_adc128s022_emulator
// Drives the emulator as an ADC128S022 master would (16-cycle SCLK half
// period), keeps a channel/address model of the chip, and checks returned
// words, frame_channel, frame_done timing and idle/reset levels through a
// scoreboard monitor.
// ----------------------------------------------------------------------------
module tb_adc128s022_emulator;

  localparam int SYNC     = 2;
  localparam int HALF     = 16;
  localparam int PK_IDLE  = 0;
  localparam int PK_BUSY  = 1;
  localparam int PK_RESET = 2;
  localparam int PK_END   = 3;

  typedef struct packed {
    logic [15:0] word;
    logic [2:0]  ch;
  } exp_t;

  typedef struct packed {
    int due;
    int kind;
    int id;
  } probe_t;

  logic        clk_in = 1'b0;
  logic        reset;
  logic [95:0] ch_data;
  logic        frame_done;
  logic [2:0]  frame_channel;
  logic        busy;

  adc128s022_emulator_if spi();

  adc128s022_emulator #(.SYNC_STAGES(SYNC)) dut (
    .clk_in        (clk_in),
    .reset         (reset),
    .spi           (spi),
    .ch_data       (ch_data),
    .frame_done    (frame_done),
    .frame_channel (frame_channel),
    .busy          (busy)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // Model of the chip: channel values and the currently selected channel
  logic [11:0] ch_vals [8];
  logic [2:0]  m_next_ch;

  exp_t        exp_q[$];
  probe_t      probe_q[$];
  logic [15:0] rx_word_last = '0;
  int          rise16_cyc   = 0;
  int          step         = 0;
  int          n_cmp        = 0;
  int          n_err        = 0;

  int          mode;
  logic [2:0]  a;

  // --------------------------------------------------------------------------
  // Monitor: compares words on frame_done and services level probes
  // --------------------------------------------------------------------------
  task automatic check(input string name, input int id, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s (step %0d, cycle %0d): got 0x%0h, required 0x%0h", name, id, cyc, act, req);
    end
  endtask

  exp_t   mon_e;
  probe_t mon_p;

  always @(negedge clk_in) begin
    if (frame_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_frame_done", step, 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("rx_word", step, int'(rx_word_last), int'(mon_e.word));
        check("frame_channel", step, int'(frame_channel), int'(mon_e.ch));
        check("frame_done_latency", step, cyc - rise16_cyc, SYNC + 1);
      end
    end
    while (probe_q.size() != 0 && probe_q[0].due <= cyc) begin
      mon_p = probe_q.pop_front();
      check("probe_on_time", mon_p.id, mon_p.due, cyc);
      case (mon_p.kind)
        PK_IDLE: begin
          check("idle_sdat", mon_p.id, int'(spi.ADC_SDAT), 0);
          check("idle_busy", mon_p.id, int'(busy), 0);
          check("idle_frame_done", mon_p.id, int'(frame_done), 0);
        end
        PK_BUSY: begin
          check("start_busy", mon_p.id, int'(busy), 1);
          check("start_sdat", mon_p.id, int'(spi.ADC_SDAT), 0);
        end
        PK_RESET: begin
          check("reset_sdat", mon_p.id, int'(spi.ADC_SDAT), 0);
          check("reset_busy", mon_p.id, int'(busy), 0);
          check("reset_frame_done", mon_p.id, int'(frame_done), 0);
          check("reset_frame_channel", mon_p.id, int'(frame_channel), 0);
        end
        default: begin
          check("words_outstanding", mon_p.id, exp_q.size(), 0);
        end
      endcase
    end
  end

  always @(posedge clk_in) begin
    if (cyc > 60000) begin
      $display("FAIL watchdog: cycle %0d exceeded budget of 60000", cyc);
      $fatal(1, "watchdog expired");
    end
  end

  // --------------------------------------------------------------------------
  // Master-side stimulus
  // --------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic push_probe(input int kind, input int delay);
    probe_t p;
    p.due  = cyc + delay;
    p.kind = kind;
    p.id   = step;
    probe_q.push_back(p);
  endtask

  task automatic set_ch(input int k, input logic [11:0] v);
    ch_vals[k]          = v;
    ch_data[k*12 +: 12] = v;
  endtask

  task automatic start_frame();
    tick(HALF);
    spi.ADC_CS_N = 1'b0;
    push_probe(PK_BUSY, SYNC + 1);
  endtask

  task automatic end_frame();
    tick(HALF);
    spi.ADC_CS_N = 1'b1;
    push_probe(PK_IDLE, SYNC + 1);
  endtask

  // One 16-cycle word with CS already low. abort_at / chg_at / rst_at name a
  // rise number (0 = unused).
  task automatic run_word(input logic [2:0] addr, input int abort_at,
                          input int chg_at, input logic [11:0] chg_val,
                          input int rst_at);
    exp_t        e;
    logic [15:0] rx;
    e.word = {4'h0, ch_vals[m_next_ch]};
    e.ch   = m_next_ch;
    exp_q.push_back(e);
    rx = '0;
    for (int r = 1; r <= 16; r++) begin
      tick(HALF);
      spi.ADC_SCLK = 1'b0;
      case (r)
        3:       spi.ADC_SADDR = addr[2];
        4:       spi.ADC_SADDR = addr[1];
        5:       spi.ADC_SADDR = addr[0];
        default: spi.ADC_SADDR = 1'($urandom_range(0, 1));
      endcase
      tick(HALF);
      rx = {rx[14:0], spi.ADC_SDAT};
      spi.ADC_SCLK = 1'b1;
      if (r == 5) m_next_ch = addr;
      if (r == 16) begin
        rx_word_last = rx;
        rise16_cyc   = cyc;
      end
      if (r == chg_at) set_ch(0, chg_val);
      if (r == rst_at) begin
        reset = 1'b0;
        push_probe(PK_RESET, 1);
        void'(exp_q.pop_back());
        m_next_ch = 3'd0;
        tick(3);
        reset = 1'b1;
        return;
      end
      if (r == abort_at) begin
        tick(HALF);
        spi.ADC_CS_N = 1'b1;
        void'(exp_q.pop_back());
        push_probe(PK_IDLE, SYNC + 1);
        return;
      end
    end
  endtask

  task automatic full_frame(input logic [2:0] addr);
    start_frame();
    run_word(addr, 0, 0, 12'h000, 0);
    end_frame();
  endtask

  task automatic toggle_sclk(input int n);
    for (int i = 0; i < n; i++) begin
      tick(HALF);
      spi.ADC_SCLK  = 1'b0;
      spi.ADC_SADDR = 1'($urandom_range(0, 1));
      tick(HALF);
      spi.ADC_SCLK = 1'b1;
      push_probe(PK_IDLE, SYNC + 1);
    end
  endtask

  initial begin
    reset         = 1'b0;
    spi.ADC_CS_N  = 1'b1;
    spi.ADC_SCLK  = 1'b1;
    spi.ADC_SADDR = 1'b0;
    ch_data       = '0;
    for (int k = 0; k < 8; k++) ch_vals[k] = 12'h000;
    m_next_ch = 3'd0;

    tick(2);
    push_probe(PK_RESET, 1);
    tick(4);
    reset = 1'b1;

    // First frame after reset returns channel 0
    step = 1;  set_ch(0, 12'hA5C); full_frame(3'b000);
    // Address select
    step = 2;  full_frame(3'b101);
    step = 3;  set_ch(5, 12'h123); full_frame(3'b111);
    step = 4;  set_ch(7, 12'hFFF); full_frame(3'b000);
    // Continuous mode: ch0 word selects ch2 for the second word
    step = 5;  set_ch(2, 12'h456);
    start_frame();
    run_word(3'b010, 0, 0, 12'h000, 0);
    run_word(3'b000, 0, 0, 12'h000, 0);
    end_frame();
    // Abort after rise 8 keeps the rise-5 address
    step = 6;  start_frame(); run_word(3'b011, 8, 0, 12'h000, 0);
    step = 7;  set_ch(3, 12'($urandom)); full_frame(3'b100);
    // Abort before rise 5 leaves next_ch untouched
    step = 8;  start_frame(); run_word(3'b001, 4, 0, 12'h000, 0);
    step = 9;  set_ch(4, 12'($urandom)); full_frame(3'b000);
    // ch0 changes mid-frame: word in flight unaffected
    step = 10; start_frame(); run_word(3'b000, 0, 4, 12'h321, 0); end_frame();
    step = 11; full_frame(3'b110);
    // Reset at rise 10 with CS held low
    step = 12; start_frame(); run_word(3'($urandom), 0, 0, 12'h000, 10);
    toggle_sclk(4);
    tick(HALF);
    spi.ADC_CS_N = 1'b1;
    step = 13; full_frame(3'($urandom));
    // SCLK activity with CS high
    step = 14; toggle_sclk(6);

    // Randomized frames: single, continuous, abort + recovery
    for (int it = 0; it < 8; it++) begin
      step = 20 + it;
      for (int k = 0; k < 8; k++) set_ch(k, 12'($urandom));
      mode = int'($urandom_range(0, 2));
      a    = 3'($urandom);
      case (mode)
        0: full_frame(a);
        1: begin
          start_frame();
          run_word(a, 0, 0, 12'h000, 0);
          run_word(3'($urandom), 0, 0, 12'h000, 0);
          end_frame();
        end
        default: begin
          start_frame();
          run_word(a, int'($urandom_range(1, 15)), 0, 12'h000, 0);
          full_frame(3'($urandom));
        end
      endcase
    end

    step = 99;
    tick(20);
    push_probe(PK_END, 2);
    tick(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
